// File: rtl/pe_mac_pipe.sv
// Pipelined INT MAC processing element for the output-stationary systolic array.
// Operand register, MUL_STAGES product registers, then accumulate/emit stage.
module pe_mac_pipe #(
  parameter int unsigned ELEM_BITS  = 8,
  parameter int unsigned ACC_BITS   = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ELEM_BITS-1:0] a_in,
  input  logic [ELEM_BITS-1:0] b_in,
  input  logic                 first_in,
  input  logic                 last_in,
  input  logic                 signed_mode,
  output logic [ELEM_BITS-1:0] a_out,
  output logic [ELEM_BITS-1:0] b_out,
  output logic                 valid_out,
  output logic                 first_out,
  output logic                 last_out,
  output logic                 res_valid,
  output logic [ACC_BITS-1:0]  res_data,
  output logic                 ovf
);

  localparam int unsigned PW = 2 * ELEM_BITS;
  localparam int unsigned AW = ACC_BITS + 1;
  localparam int unsigned SW = PW + 4;

  typedef struct packed {
    logic [PW-1:0] prod;
    logic          v;
    logic          f;
    logic          l;
    logic          s;
  } stage_t;

  logic [ELEM_BITS-1:0] op_a, op_b;
  logic                 op_v, op_f, op_l, op_s;

  logic [MUL_STAGES*SW-1:0] pipe_q;
  logic [(MUL_STAGES+1)*SW-1:0] pipe_shift;
  stage_t                   head, tail;

  logic [PW-1:0]  mul_prod;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] acc_next;
  logic                ovf_next;
  logic                of;

  // Operands widened by one bit so one signed multiplier serves both modes.
  always_comb begin
    logic signed [ELEM_BITS:0]   ax, bx;
    logic signed [2*ELEM_BITS+1:0] full;
    ax       = $signed({op_s & op_a[ELEM_BITS-1], op_a});
    bx       = $signed({op_s & op_b[ELEM_BITS-1], op_b});
    full     = ax * bx;
    mul_prod = full[PW-1:0];
  end

  always_comb begin
    head.prod = mul_prod;
    head.v    = op_v;
    head.f    = op_f;
    head.l    = op_l;
    head.s    = op_s;
  end

  // Shift by concatenation so MUL_STAGES=1 needs no special case.
  assign pipe_shift = {pipe_q, head};
  assign tail       = pipe_q[MUL_STAGES*SW-1 -: SW];

  always_comb begin
    logic [AW-1:0] p_ext, base, sum, sat_val;
    p_ext = tail.s ? {{(AW-PW){tail.prod[PW-1]}}, tail.prod}
                   : {{(AW-PW){1'b0}}, tail.prod};
    if (tail.f)      base = '0;
    else if (tail.s) base = {acc[ACC_BITS-1], acc};
    else             base = {1'b0, acc};
    sum = base + p_ext;
    if (tail.s) begin
      of      = sum[AW-1] ^ sum[AW-2];
      sat_val = sum[AW-1] ? {2'b11, {(ACC_BITS-1){1'b0}}}
                          : {2'b00, {(ACC_BITS-1){1'b1}}};
    end else begin
      of      = sum[AW-1];
      sat_val = {1'b0, {ACC_BITS{1'b1}}};
    end
    acc_next = (SATURATE && of) ? sat_val[ACC_BITS-1:0] : sum[ACC_BITS-1:0];
    ovf_next = (tail.f ? 1'b0 : ovf) | of;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_v      <= 1'b0;
      op_f      <= 1'b0;
      op_l      <= 1'b0;
      op_s      <= 1'b0;
      pipe_q    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      valid_out <= in_valid;
      first_out <= first_in & in_valid;
      last_out  <= last_in & in_valid;
      op_a      <= a_in;
      op_b      <= b_in;
      op_v      <= in_valid;
      op_f      <= first_in & in_valid;
      op_l      <= last_in & in_valid;
      op_s      <= signed_mode;
      pipe_q    <= pipe_shift[MUL_STAGES*SW-1:0];
      res_valid <= tail.v & tail.l;
      if (tail.v) begin
        acc <= acc_next;
        ovf <= ovf_next;
        if (tail.l) res_data <= acc_next;
      end
    end
  end

endmodule
